// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode,
// combinational terminal count and registered limit-event flags.
module param_updown_counter #(
  parameter int     WIDTH     = 4,
  parameter longint MOD_VAL   = 16,
  parameter int     SATURATE  = 0,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  // Limits are held in WIDTH+1 bits so MOD_VAL == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   LAST     = (WIDTH+1)'(MOD_VAL - 1);
  localparam logic [WIDTH-1:0] LAST_W   = LAST[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_W  = WIDTH'(RESET_VAL);
  localparam logic             SAT_MODE = (SATURATE != 0);

  logic             at_max;
  logic             at_zero;
  logic             limit_step;
  logic [WIDTH-1:0] count_nxt;

  assign at_max     = ({1'b0, count} == LAST);
  assign at_zero    = (count == '0);
  assign tc         = en & (up_dn ? at_max : at_zero);
  assign limit_step = tc & ~load;

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = ({1'b0, load_val} > LAST) ? LAST_W : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max)
          count_nxt = SAT_MODE ? count : '0;
        else
          count_nxt = count + WIDTH'(1);
      end else begin
        if (at_zero)
          count_nxt = SAT_MODE ? count : LAST_W;
        else
          count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= RESET_W;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= limit_step;
      // A limit event on the same edge as clr_flag keeps the flag set.
      if (limit_step)
        ovf_sticky <= 1'b1;
      else if (clr_flag)
        ovf_sticky <= 1'b0;
    end
  end

endmodule
